// File: rtl/biu_pkg.sv
// Shared types and constants for the BIU round-robin arbiter.
package biu_pkg;

  typedef enum logic [1:0] {
    BIU_IDLE    = 2'd0,
    BIU_ISSUE   = 2'd1,
    BIU_WAIT_RD = 2'd2
  } biu_state_e;

  // A timed-out read returns a word of all ones: replicate this bit across the data width.
  localparam logic BIU_TIMEOUT_FILL = 1'b1;

endpackage

// File: rtl/biu_rr_pick.sv
// Combinational round-robin picker: first requester found searching upward from last+1.
module biu_rr_pick #(
  parameter int NUM_MASTERS = 4
) (
  input  logic [NUM_MASTERS-1:0]         req,
  input  logic [$clog2(NUM_MASTERS)-1:0] last,
  output logic [$clog2(NUM_MASTERS)-1:0] grant,
  output logic                           any
);

  localparam int IW = $clog2(NUM_MASTERS);

  // NOTE: every output of a combinational block gets a default before any branch,
  // otherwise paths that skip an assignment infer a latch.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      if (!any && req[(int'(last) + k) % NUM_MASTERS]) begin
        grant = IW'((int'(last) + k) % NUM_MASTERS);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/biu_rr_arbiter.sv
// N-to-1 BIU arbiter: latches one request per master, serialises them round-robin
// onto the slave port and routes read data (or a timeout error) back to the requester.
module biu_rr_arbiter
  import biu_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_out,
  input  logic [NUM_MASTERS-1:0]            m_rnw,
  input  logic [NUM_MASTERS-1:0]            m_en,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_in,
  output logic [NUM_MASTERS-1:0]            m_data_valid,
  output logic [NUM_MASTERS-1:0]            m_busy,
  output logic [NUM_MASTERS-1:0]            m_error,
  output logic [ADDR_WIDTH-1:0]             s_address,
  output logic [DATA_WIDTH-1:0]             s_data_out,
  output logic                              s_rnw,
  output logic                              s_en,
  input  logic [DATA_WIDTH-1:0]             s_data_in,
  input  logic                              s_data_valid
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Completion fires on the edge after the counter's last value, i.e. TIMEOUT cycles in WAIT_RD.
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [NUM_MASTERS-1:0] pending;
  logic [ADDR_WIDTH-1:0]  slot_addr [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]  slot_data [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] slot_rnw;

  biu_state_e    state, state_next;
  logic [IW-1:0] grant, last, pick_grant;
  logic          pick_any;
  logic [CW-1:0] cnt;
  logic          rd_done, rd_timeout;

  assign m_busy = pending;

  biu_rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .req   (pending),
    .last  (last),
    .grant (pick_grant),
    .any   (pick_any)
  );

  // NOTE: slot storage is plain data qualified by pending, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (m_en[i] && !pending[i]) begin
        slot_addr[i] <= m_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        slot_data[i] <= m_data_out[i*DATA_WIDTH +: DATA_WIDTH];
        slot_rnw[i]  <= m_rnw[i];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BIU_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    rd_done    = 1'b0;
    rd_timeout = 1'b0;
    unique case (state)
      BIU_IDLE:  if (pick_any) state_next = BIU_ISSUE;
      BIU_ISSUE: state_next = slot_rnw[grant] ? BIU_WAIT_RD : BIU_IDLE;
      BIU_WAIT_RD: begin
        // Data arriving on the timeout cycle wins, so no error is raised.
        if (s_data_valid)                            rd_done    = 1'b1;
        else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) rd_timeout = 1'b1;
        if (rd_done || rd_timeout) state_next = BIU_IDLE;
      end
      default: state_next = BIU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending      <= '0;
      grant        <= '0;
      last         <= IW'(NUM_MASTERS - 1);
      cnt          <= '0;
      s_en         <= 1'b0;
      s_address    <= '0;
      s_data_out   <= '0;
      s_rnw        <= 1'b0;
      m_data_in    <= '0;
      m_data_valid <= '0;
      m_error      <= '0;
    end else begin
      s_en         <= 1'b0;
      m_data_valid <= '0;
      m_error      <= '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (m_en[i] && !pending[i]) pending[i] <= 1'b1;
      end
      unique case (state)
        BIU_IDLE: begin
          if (pick_any) begin
            grant      <= pick_grant;
            s_en       <= 1'b1;
            s_address  <= slot_addr[pick_grant];
            s_data_out <= slot_data[pick_grant];
            s_rnw      <= slot_rnw[pick_grant];
          end
        end
        BIU_ISSUE: begin
          last <= grant;
          cnt  <= '0;
          if (!slot_rnw[grant]) pending[grant] <= 1'b0;
        end
        BIU_WAIT_RD: begin
          cnt <= cnt + CW'(1);
          if (rd_done || rd_timeout) begin
            m_data_in[grant*DATA_WIDTH +: DATA_WIDTH] <=
              rd_done ? s_data_in : {DATA_WIDTH{BIU_TIMEOUT_FILL}};
            m_data_valid[grant] <= 1'b1;
            m_error[grant]      <= rd_timeout;
            pending[grant]      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
